// File: rtl/osc_edge_counter_pkg.sv
// Shared definitions for the oscillator edge counter: FSM encoding and default widths.
package osc_edge_counter_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int WIN_W_DEF = 12;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ARM   = ST_ARM,
        COUNT = ST_COUNT,
        HOLD  = ST_HOLD
    } state_e;

endpackage

// File: rtl/osc_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 0.
module osc_sync2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/osc_edge_counter.sv
// Counts synchronized OSC rising edges over a programmable window of CLK cycles and
// returns the count through a valid/ready handshake.
module osc_edge_counter
    import osc_edge_counter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             OSC,
    input  logic             START,
    input  logic [WIN_W-1:0] WIN,
    output logic [CNT_W-1:0] DOUT,
    output logic             VALID,
    input  logic             READY,
    output logic             BUSY,
    output logic             OVF
);

    localparam logic [WIN_W:0] WIN_ONE  = {{WIN_W{1'b0}}, 1'b1};
    localparam logic [WIN_W:0] WIN_FULL = {1'b1, {WIN_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIN_W:0]   win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             osc_s;
    logic             osc_dly_q;
    logic             edge_pulse;
    logic [WIN_W:0]   win_load;

    osc_sync2 u_sync (
        .clk_i   (CLK),
        .rst_n_i (RN),
        .d_i     (OSC),
        .q_o     (osc_s)
    );

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            osc_dly_q <= 1'b0;
        end else begin
            osc_dly_q <= osc_s;
        end
    end

    assign edge_pulse = osc_s & ~osc_dly_q;

    // A zero window request stands for the full 2^WIN_W span, hence the extra bit.
    assign win_load = (WIN == '0) ? WIN_FULL : {1'b0, WIN};

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = ARM;
                    win_d   = win_load;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ARM: begin
                state_d = COUNT;
            end
            COUNT: begin
                if (edge_pulse) begin
                    if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                win_d = win_q - WIN_ONE;
                // The final window cycle's edge is included in the latched result.
                if (win_q == WIN_ONE) begin
                    state_d = HOLD;
                    dout_d  = cnt_d;
                end
            end
            HOLD: begin
                if (READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            win_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign DOUT  = dout_q;
    assign OVF   = ovf_q;
    assign VALID = (state_q == HOLD);
    assign BUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_osc_edge_counter.sv
// Scoreboard bench for osc_edge_counter: a 16-bit instance for timing/handshake
// scenarios and an 8-bit instance for saturation.
module tb_osc_edge_counter;

    logic        CLK = 1'b0;
    logic        RN = 1'b0;
    logic        OSC = 1'b0;
    logic        START = 1'b0;
    logic [11:0] WIN = '0;
    logic        READY = 1'b0;
    logic [15:0] DOUT;
    logic        VALID, BUSY, OVF;

    logic        START_S = 1'b0;
    logic        READY_S = 1'b0;
    logic [7:0]  DOUT_S;
    logic        VALID_S, BUSY_S, OVF_S;

    int n_checks = 0;
    int n_fail = 0;
    int osc_div = 0;
    int osc_ph = 0;

    typedef struct {
        int lo;
        int hi;
        bit ovf;
        int lat;
    } exp_t;

    exp_t sb[$];

    always #5 CLK = ~CLK;

    // OSC as an integer divider of CLK, changed only on falling edges.
    always @(negedge CLK) begin
        if (osc_div == 0) begin
            OSC = 1'b0;
        end else begin
            if (osc_ph >= osc_div - 1) osc_ph = 0;
            else osc_ph = osc_ph + 1;
            OSC = (osc_ph < osc_div / 2);
        end
    end

    osc_edge_counter #(.CNT_W(16), .WIN_W(12)) u_dut (
        .CLK(CLK), .RN(RN), .OSC(OSC), .START(START), .WIN(WIN),
        .DOUT(DOUT), .VALID(VALID), .READY(READY), .BUSY(BUSY), .OVF(OVF)
    );

    osc_edge_counter #(.CNT_W(8), .WIN_W(12)) u_sat (
        .CLK(CLK), .RN(RN), .OSC(OSC), .START(START_S), .WIN(WIN),
        .DOUT(DOUT_S), .VALID(VALID_S), .READY(READY_S), .BUSY(BUSY_S), .OVF(OVF_S)
    );

    // Returns the number of falling edges until VALID (1 = first edge after START
    // was sampled), or -1 if the budget runs out. START is dropped after one cycle.
    task automatic wait_valid(input bit sat, input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge CLK);
            START = 1'b0;
            START_S = 1'b0;
            WIN = 12'h5A5;
            if ((sat ? VALID_S : VALID) === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RN = 1'b0;
        #1;
        n_checks++;
        if ({VALID, BUSY, OVF, DOUT} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_main: got valid=%b busy=%b ovf=%b dout=%0d, want all 0", VALID, BUSY, OVF, DOUT);
        end
        n_checks++;
        if ({VALID_S, BUSY_S, OVF_S, DOUT_S} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_sat: got valid=%b busy=%b ovf=%b dout=%0d, want all 0", VALID_S, BUSY_S, OVF_S, DOUT_S);
        end
        repeat (3) @(negedge CLK);
        RN = 1'b1;
        @(negedge CLK);
        $display("reset: released");
    endtask

    task automatic test_normal();
        int lat;
        exp_t e;
        osc_div = 4;
        READY = 1'b1;
        repeat (8) @(negedge CLK);
        sb.push_back('{25, 25, 1'b0, 102});
        WIN = 12'd100;
        START = 1'b1;
        wait_valid(1'b0, 300, lat);
        e = sb.pop_front();
        n_checks++;
        if (lat != e.lat) begin
            n_fail++;
            $display("FAIL normal_latency: got %0d, want %0d", lat, e.lat);
        end
        n_checks++;
        if (DOUT < e.lo || DOUT > e.hi || OVF !== e.ovf) begin
            n_fail++;
            $display("FAIL normal_result: got dout=%0d ovf=%b, want dout=%0d ovf=%b", DOUT, OVF, e.lo, e.ovf);
        end
        @(negedge CLK);
        n_checks++;
        if (VALID !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_release: got valid=%b busy=%b, want 0 0", VALID, BUSY);
        end
        $display("normal: win=100 lat=%0d dout=%0d ovf=%b", lat, DOUT, OVF);
    endtask

    task automatic test_full_window();
        int lat;
        exp_t e;
        osc_div = 4;
        READY = 1'b1;
        sb.push_back('{1024, 1024, 1'b0, 4098});
        WIN = 12'd0;
        START = 1'b1;
        wait_valid(1'b0, 4300, lat);
        e = sb.pop_front();
        n_checks++;
        if (lat != e.lat) begin
            n_fail++;
            $display("FAIL full_latency: got %0d, want %0d", lat, e.lat);
        end
        n_checks++;
        if (DOUT < e.lo || DOUT > e.hi || OVF !== e.ovf) begin
            n_fail++;
            $display("FAIL full_result: got dout=%0d ovf=%b, want dout=%0d ovf=%b", DOUT, OVF, e.lo, e.ovf);
        end
        @(negedge CLK);
        $display("full_window: win=0 lat=%0d dout=%0d", lat, DOUT);
    endtask

    task automatic test_saturation();
        int lat;
        exp_t e;
        osc_div = 6;
        READY_S = 1'b1;
        repeat (6) @(negedge CLK);
        sb.push_back('{255, 255, 1'b1, 2002});
        WIN = 12'd2000;
        START_S = 1'b1;
        wait_valid(1'b1, 2200, lat);
        e = sb.pop_front();
        n_checks++;
        if (lat != e.lat) begin
            n_fail++;
            $display("FAIL sat_latency: got %0d, want %0d", lat, e.lat);
        end
        n_checks++;
        if (DOUT_S < e.lo || DOUT_S > e.hi || OVF_S !== e.ovf) begin
            n_fail++;
            $display("FAIL sat_result: got dout=%0d ovf=%b, want dout=%0d ovf=%b", DOUT_S, OVF_S, e.lo, e.ovf);
        end
        @(negedge CLK);
        n_checks++;
        if (VALID_S !== 1'b0 || OVF_S !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_sticky: got valid=%b ovf=%b, want 0 1", VALID_S, OVF_S);
        end
        $display("saturation: win=2000 lat=%0d dout=%0d ovf=%b", lat, DOUT_S, OVF_S);
    endtask

    task automatic test_backpressure();
        int lat;
        exp_t e;
        logic [15:0] held;
        int bad;
        osc_div = 4;
        READY = 1'b0;
        sb.push_back('{25, 25, 1'b0, 102});
        WIN = 12'd100;
        START = 1'b1;
        wait_valid(1'b0, 300, lat);
        e = sb.pop_front();
        n_checks++;
        if (lat != e.lat || DOUT < e.lo || DOUT > e.hi) begin
            n_fail++;
            $display("FAIL bp_result: got lat=%0d dout=%0d, want lat=%0d dout=%0d", lat, DOUT, e.lat, e.lo);
        end
        held = DOUT;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (VALID !== 1'b1 || BUSY !== 1'b1 || DOUT !== held) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d unstable cycles (last valid=%b dout=%0d), want 0 (dout=%0d)", bad, VALID, DOUT, held);
        end
        READY = 1'b1;
        @(negedge CLK);
        READY = 1'b0;
        n_checks++;
        if (VALID !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got valid=%b busy=%b, want 0 0", VALID, BUSY);
        end
        $display("backpressure: held dout=%0d for 50 cycles", held);
    endtask

    task automatic test_start_while_busy();
        int lat;
        exp_t e;
        int idle_bad;
        osc_div = 4;
        READY = 1'b0;
        sb.push_back('{10, 10, 1'b0, 42});
        WIN = 12'd40;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        n_checks++;
        if (BUSY !== 1'b1 || VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_arm: got busy=%b valid=%b, want 1 0", BUSY, VALID);
        end
        repeat (19) @(negedge CLK);
        WIN = 12'd5;
        START = 1'b1;
        wait_valid(1'b0, 200, lat);
        if (lat > 0) lat = lat + 20;
        e = sb.pop_front();
        n_checks++;
        if (lat != e.lat || DOUT < e.lo || DOUT > e.hi) begin
            n_fail++;
            $display("FAIL busy_count: got lat=%0d dout=%0d, want lat=%0d dout=%0d", lat, DOUT, e.lat, e.lo);
        end
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        n_checks++;
        if (VALID !== 1'b1 || DOUT !== 16'(e.lo)) begin
            n_fail++;
            $display("FAIL busy_hold_start: got valid=%b dout=%0d, want 1 %0d", VALID, DOUT, e.lo);
        end
        READY = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        READY = 1'b0;
        START = 1'b0;
        idle_bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (BUSY !== 1'b0 || VALID !== 1'b0) idle_bad++;
            @(negedge CLK);
        end
        n_checks++;
        if (idle_bad != 0) begin
            n_fail++;
            $display("FAIL busy_no_restart: got %0d busy cycles after handshake, want 0", idle_bad);
        end
        $display("start_while_busy: lat=%0d dout=%0d", lat, e.lo);
    endtask

    task automatic test_reset_mid_count();
        int lat;
        exp_t e;
        osc_div = 4;
        READY = 1'b1;
        WIN = 12'd100;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (39) @(negedge CLK);
        RN = 1'b0;
        #1;
        n_checks++;
        if ({VALID, BUSY, OVF, DOUT} !== 19'd0) begin
            n_fail++;
            $display("FAIL midreset_clear: got valid=%b busy=%b ovf=%b dout=%0d, want all 0", VALID, BUSY, OVF, DOUT);
        end
        @(negedge CLK);
        RN = 1'b1;
        repeat (4) @(negedge CLK);
        sb.push_back('{2, 3, 1'b0, 12});
        WIN = 12'd10;
        START = 1'b1;
        wait_valid(1'b0, 100, lat);
        e = sb.pop_front();
        n_checks++;
        if (lat != e.lat) begin
            n_fail++;
            $display("FAIL midreset_latency: got %0d, want %0d", lat, e.lat);
        end
        n_checks++;
        if (DOUT < e.lo || DOUT > e.hi || OVF !== e.ovf) begin
            n_fail++;
            $display("FAIL midreset_result: got dout=%0d ovf=%b, want %0d..%0d ovf=%b", DOUT, OVF, e.lo, e.hi, e.ovf);
        end
        @(negedge CLK);
        $display("reset_mid_count: rerun win=10 dout=%0d", DOUT);
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_normal();
        test_full_window();
        test_saturation();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
